// File: rtl/wb_memtest_master_if.sv
// wb_memtest_master_if: Wishbone B3 signal bundle between the memory-test master and the interconnect
interface wb_memtest_master_if;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        cyc_o;
  logic        stb_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;
  modport master (output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, cti_o, bte_o, input dat_i, ack_i, err_i, rty_i);
  modport slave (input adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, cti_o, bte_o, output dat_i, ack_i, err_i, rty_i);
endinterface

// File: rtl/wb_memtest_master.sv
// wb_memtest_master: Wishbone B3 master writing an LFSR pattern in bursts, then reading it back and counting mismatches
module wb_memtest_master #(
  parameter int          BURST_LEN = 8,
  parameter logic [31:0] LFSR_SEED = 32'hACE1ACE1
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n_i,
  input  logic                       start_i,
  input  logic [31:0]                base_adr_i,
  input  logic [23:0]                num_words_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       bus_err_o,
  output logic [15:0]                err_cnt_o,
  output logic [31:0]                first_err_adr_o,
  wb_memtest_master_if.master        wbm
);
  typedef enum logic [2:0] {IDLE, WR_BURST, WR_GAP, RD_BURST, RD_GAP, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d, lfsr_q, lfsr_d, base_q, base_d, first_q, first_d;
  logic [23:0] num_q, num_d, rem_q, rem_d, n_src;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [4:0]  left_q, left_d, n;
  logic [2:0]  cti_q, cti_d;
  logic        cyc_q, cyc_d, we_q, we_d, busy_q, busy_d, done_q, done_d, bus_err_q, bus_err_d;
  logic [31:0] base_in, lfsr_nx;
  logic        rd_start;
  assign base_in  = base_adr_i & 32'hFFFF_FFFC;
  assign lfsr_nx  = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? 32'h0040_0007 : 32'h0);
  assign rd_start = state_q == WR_GAP && rem_q == 24'd0;
  // words available for the burst about to start: the request, the whole range again, or what is left
  assign n_src    = state_q == IDLE ? num_words_i : rd_start ? num_q : rem_q;
  assign n        = n_src < 24'(BURST_LEN) ? n_src[4:0] : 5'(BURST_LEN);
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    lfsr_d    = lfsr_q;
    base_d    = base_q;
    first_d   = first_q;
    num_d     = num_q;
    rem_d     = rem_q;
    err_cnt_d = err_cnt_q;
    left_d    = left_q;
    cti_d     = cti_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bus_err_d = bus_err_q;
    case (state_q)
      IDLE: if (start_i) begin
        base_d    = base_in;
        num_d     = num_words_i;
        err_cnt_d = 16'h0;
        first_d   = 32'h0;
        bus_err_d = 1'b0;
        busy_d    = 1'b1;
        lfsr_d    = LFSR_SEED;
        state_d   = num_words_i == 24'd0 ? DONE : WR_BURST;
        if (num_words_i != 24'd0) begin
          cyc_d  = 1'b1;
          we_d   = 1'b1;
          adr_d  = base_in;
          dat_d  = LFSR_SEED;
          rem_d  = num_words_i;
          left_d = n;
          cti_d  = n == 5'd1 ? 3'b000 : 3'b010;
        end
      end
      WR_BURST, RD_BURST: begin
        if (wbm.err_i) begin
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          dat_d     = 32'h0;
          cti_d     = 3'b000;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else if (wbm.ack_i) begin
          lfsr_d = lfsr_nx;
          adr_d  = adr_q + 32'd4;
          rem_d  = rem_q - 24'd1;
          left_d = left_q - 5'd1;
          cti_d  = left_q == 5'd2 ? 3'b111 : 3'b010;
          dat_d  = we_q ? lfsr_nx : 32'h0;
          if (!we_q && wbm.dat_i != lfsr_q) begin
            err_cnt_d = &err_cnt_q ? err_cnt_q : err_cnt_q + 16'd1;
            first_d   = err_cnt_q == 16'h0 ? adr_q : first_q;
          end
          if (left_q == 5'd1) begin
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            dat_d   = 32'h0;
            cti_d   = 3'b000;
            state_d = we_q ? WR_GAP : RD_GAP;
          end
        end
      end
      WR_GAP: begin
        cyc_d   = 1'b1;
        left_d  = n;
        cti_d   = n == 5'd1 ? 3'b000 : 3'b010;
        we_d    = !rd_start;
        dat_d   = rd_start ? 32'h0 : lfsr_q;
        lfsr_d  = rd_start ? LFSR_SEED : lfsr_q;
        adr_d   = rd_start ? base_q : adr_q;
        rem_d   = rd_start ? num_q : rem_q;
        state_d = rd_start ? RD_BURST : WR_BURST;
      end
      RD_GAP: begin
        cyc_d   = rem_q != 24'd0;
        left_d  = n;
        cti_d   = rem_q == 24'd0 ? 3'b000 : n == 5'd1 ? 3'b000 : 3'b010;
        state_d = rem_q == 24'd0 ? DONE : RD_BURST;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      state_q   <= IDLE;
      adr_q     <= 32'h0;
      dat_q     <= 32'h0;
      lfsr_q    <= LFSR_SEED;
      base_q    <= 32'h0;
      first_q   <= 32'h0;
      num_q     <= 24'h0;
      rem_q     <= 24'h0;
      err_cnt_q <= 16'h0;
      left_q    <= 5'h0;
      cti_q     <= 3'b000;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      lfsr_q    <= lfsr_d;
      base_q    <= base_d;
      first_q   <= first_d;
      num_q     <= num_d;
      rem_q     <= rem_d;
      err_cnt_q <= err_cnt_d;
      left_q    <= left_d;
      cti_q     <= cti_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bus_err_q <= bus_err_d;
    end
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign bus_err_o       = bus_err_q;
  assign err_cnt_o       = err_cnt_q;
  assign first_err_adr_o = first_q;
  assign wbm.adr_o       = adr_q;
  assign wbm.dat_o       = dat_q;
  assign wbm.sel_o       = cyc_q ? 4'hF : 4'h0;
  assign wbm.we_o        = we_q;
  assign wbm.cyc_o       = cyc_q;
  assign wbm.stb_o       = cyc_q;
  assign wbm.cti_o       = cti_q;
  assign wbm.bte_o       = 2'b00;
endmodule

// File: tb/tb_wb_memtest_master.sv
// tb_wb_memtest_master: directed and randomized runs of the memory-test master against a bench RAM slave
module tb_wb_memtest_master;
  localparam int BL = 8;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] base = 32'h0;
  logic [23:0] nw = 24'h0;
  logic        busy, done, bus_err;
  logic [15:0] err_cnt;
  logic [31:0] first_err;
  wb_memtest_master_if wbm();
  wb_memtest_master #(.BURST_LEN(BL), .LFSR_SEED(32'hACE1ACE1)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start), .base_adr_i(base), .num_words_i(nw),
    .busy_o(busy), .done_o(done), .bus_err_o(bus_err), .err_cnt_o(err_cnt), .first_err_adr_o(first_err),
    .wbm(wbm));
  always #5 clk = ~clk;
  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat; logic [2:0] cti;} beat_t;
  beat_t       beats[$];
  int          gaps[$];
  logic [31:0] mem [int unsigned];
  int          errors = 0, checks = 0;
  bit          ideal = 1'b1;
  int          rty_at = -1, rty_len = 0, err_at = -1;
  bit          corrupt [0:63];
  logic [31:0] cur_base = 32'h0;
  int          wbeat = 0, rbeat = 0, bursts = 0, rty_cnt = 0, rty_bad = 0, sel_bad = 0, low_run = 0, rty_left = 0;
  bit          seen = 1'b0, err_pend = 1'b0, cyc_prev = 1'b0, rty_prev = 1'b0;
  logic        cyc_after_err = 1'b1;
  logic [31:0] h_adr = 32'h0, h_dat = 32'h0;
  logic [2:0]  h_cti = 3'b0;
  int          last_lat = 0;
  // accepted beats are logged on the clock edge that completes them
  always @(posedge clk) begin
    if (start && !busy && rst_n) begin
      beats.delete();
      gaps.delete();
      wbeat = 0; rbeat = 0; bursts = 0; rty_cnt = 0; rty_bad = 0; sel_bad = 0;
      seen = 1'b0; low_run = 0; cyc_after_err = 1'b1; rty_left = rty_len;
    end else if (wbm.cyc_o && wbm.stb_o) begin
      if (wbm.err_i) err_pend = 1'b1;
      else if (wbm.ack_i) begin
        beats.push_back('{wbm.we_o, wbm.adr_o, wbm.dat_o, wbm.cti_o});
        if (wbm.we_o) begin
          mem[wbm.adr_o >> 2] = wbm.dat_o;
          wbeat++;
        end else rbeat++;
      end
    end
  end
  // slave responses are chosen mid-cycle from the master's registered outputs
  always @(negedge clk) begin
    bit          act, fst;
    logic [31:0] off, rd;
    act = wbm.cyc_o && wbm.stb_o;
    fst = act && !cyc_prev;
    if (act && wbm.sel_o !== 4'hF) sel_bad++;
    if (rty_prev && (wbm.adr_o !== h_adr || wbm.dat_o !== h_dat || wbm.cti_o !== h_cti || !act)) rty_bad++;
    if (err_pend) begin
      cyc_after_err = wbm.cyc_o;
      err_pend = 1'b0;
    end
    if (busy && act) begin
      if (!cyc_prev && seen) gaps.push_back(low_run);
      if (!cyc_prev) bursts++;
      seen = 1'b1;
      low_run = 0;
    end else if (busy && seen) low_run++;
    cyc_prev = act;
    wbm.ack_i = 1'b0;
    wbm.rty_i = 1'b0;
    wbm.err_i = 1'b0;
    if (act) begin
      if (wbm.we_o && wbeat == rty_at && rty_left > 0) begin
        wbm.rty_i = 1'b1;
        rty_left--;
        rty_cnt++;
      end else if (!wbm.we_o && rbeat == err_at) begin
        wbm.err_i = 1'b1;
        wbm.ack_i = 1'b1;
      end else if (ideal ? !fst : ($urandom_range(3) != 0)) wbm.ack_i = 1'b1;
      else if (!ideal && $urandom_range(3) == 0) wbm.rty_i = 1'b1;
    end
    rty_prev = wbm.rty_i;
    h_adr = wbm.adr_o;
    h_dat = wbm.dat_o;
    h_cti = wbm.cti_o;
    rd = 32'h0;
    if (act && !wbm.we_o) begin
      rd = mem.exists(wbm.adr_o >> 2) ? mem[wbm.adr_o >> 2] : 32'h0;
      off = (wbm.adr_o - cur_base) >> 2;
      if (off < 32'd64 && corrupt[off[5:0]]) rd = rd ^ 32'h0000_0100;
    end
    wbm.dat_i = rd;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] nxt(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0);
  endfunction
  task automatic run_test(input string tag, input logic [31:0] b, input int n, input bit poke);
    logic [31:0] pat[$];
    logic [31:0] s, fa;
    int          lat, nr, ec, k, s0, bl;
    logic [2:0]  cti;
    cur_base = b & 32'hFFFF_FFFC;
    @(negedge clk);
    start = 1'b1; base = b; nw = 24'(n);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20000) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 3) begin
        start = 1'b1; base = 32'h00F0_0000; nw = 24'd1;
      end else start = 1'b0;
    end
    start = 1'b0;
    last_lat = lat;
    chk({tag, "_done"}, done, 1'b1);
    s = 32'hACE1ACE1;
    for (int i = 0; i < n; i++) begin
      pat.push_back(s);
      s = nxt(s);
    end
    nr = (err_at >= 0 && err_at < n) ? err_at : n;
    chk({tag, "_beats"}, beats.size(), n + nr);
    for (int i = 0; i < beats.size() && i < n + nr; i++) begin
      k = i < n ? i : i - n;
      s0 = k - k % BL;
      bl = (n - s0) < BL ? n - s0 : BL;
      cti = bl == 1 ? 3'b000 : (k == s0 + bl - 1) ? 3'b111 : 3'b010;
      chk({tag, "_we"}, beats[i].we, i < n);
      chk({tag, "_adr"}, beats[i].adr, cur_base + 32'(4 * k));
      chk({tag, "_cti"}, beats[i].cti, cti);
      if (i < n) chk({tag, "_wdat"}, beats[i].dat, pat[k]);
    end
    for (int i = 0; i < n; i++) chk({tag, "_mem"}, mem[(cur_base >> 2) + i], pat[i]);
    ec = 0; fa = 32'h0;
    for (int i = 0; i < nr; i++)
      if (corrupt[i]) begin
        if (ec == 0) fa = cur_base + 32'(4 * i);
        ec++;
      end
    chk({tag, "_errcnt"}, err_cnt, ec);
    chk({tag, "_firstadr"}, first_err, fa);
    chk({tag, "_buserr"}, bus_err, nr < n);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_hold"}, rty_bad, 0);
    chk({tag, "_sel"}, sel_bad, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 1'b0);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    foreach (corrupt[i]) corrupt[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cyc", wbm.cyc_o, 1'b0);
    chk("rst_stb", wbm.stb_o, 1'b0);
    chk("rst_adr", wbm.adr_o, 32'h0);
    chk("rst_dat", wbm.dat_o, 32'h0);
    chk("rst_errcnt", err_cnt, 16'h0);
    chk("rst_first", first_err, 32'h0);
    chk("rst_buserr", bus_err, 1'b0);
    rst_n = 1'b1;
    run_test("t1", 32'h100, 3, 1'b0);
    if (beats.size() == 6) begin
      chk("t1_d0", beats[0].dat, 32'hACE1ACE1);
      chk("t1_d1", beats[1].dat, 32'h598359C5);
      chk("t1_a2", beats[2].adr, 32'h108);
      chk("t1_c1", beats[1].cti, 3'b010);
      chk("t1_c2", beats[2].cti, 3'b111);
      chk("t1_rc2", beats[5].cti, 3'b111);
    end
    run_test("t2", 32'h2000, 20, 1'b1);
    chk("t2_bursts", bursts, 6);
    chk("t2_ngaps", gaps.size(), 5);
    foreach (gaps[i]) chk("t2_gap", gaps[i], 1);
    if (beats.size() >= 20) chk("t2_lastw", beats[19].adr, 32'h204C);
    corrupt[5] = 1'b1;
    run_test("t3a", 32'h1000, 12, 1'b0);
    chk("t3a_cnt", err_cnt, 16'd1);
    chk("t3a_adr", first_err, 32'h1014);
    corrupt[9] = 1'b1;
    run_test("t3b", 32'h1000, 12, 1'b0);
    chk("t3b_cnt", err_cnt, 16'd2);
    chk("t3b_adr", first_err, 32'h1014);
    foreach (corrupt[i]) corrupt[i] = 1'b0;
    rty_at = 2; rty_len = 3;
    run_test("t4", 32'h4000, 6, 1'b0);
    chk("t4_rty", rty_cnt, 3);
    rty_at = -1; rty_len = 0;
    err_at = 4; corrupt[4] = 1'b1;
    run_test("t5", 32'h5000, 10, 1'b0);
    chk("t5_rbeats", rbeat, 4);
    chk("t5_cycoff", cyc_after_err, 1'b0);
    err_at = -1; corrupt[4] = 1'b0;
    run_test("t6", 32'h5003, 2, 1'b0);
    run_test("t7", 32'h40, 0, 1'b0);
    chk("t7_lat", last_lat, 2);
    chk("t7_bursts", bursts, 0);
    @(negedge clk);
    start = 1'b1; base = 32'h3000; nw = 24'd16;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && wbeat < 3; i++) @(negedge clk);
    chk("t8_reach", wbeat >= 3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_cyc", wbm.cyc_o, 1'b0);
    chk("t8_stb", wbm.stb_o, 1'b0);
    chk("t8_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_test("t9", 32'h3000, 16, 1'b0);
    ideal = 1'b0;
    for (int r = 0; r < 6; r++) begin
      foreach (corrupt[i]) corrupt[i] = ($urandom_range(9) == 0);
      err_at = ($urandom_range(2) == 0) ? int'($urandom_range(30)) : -1;
      run_test("rnd", $urandom & 32'h000F_FFFF, int'($urandom_range(40, 1)), 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_memtest_master.md
Name: wb_memtest_master

Overview:
- Synthesizable Wishbone B3 bus master that exercises a memory slave (e.g. main RAM) on the system interconnect.
- On start it writes a pseudo-random LFSR pattern over a word range using incrementing bursts. It then reads the range back in bursts and compares each word against the regenerated pattern.
- Reports completion, mismatch count, first failing address and bus errors.
- Attaches as an additional master port on the Wishbone interconnect, alongside the CPU and debug masters.

Parameters:
- BURST_LEN, 8, maximum beats per burst; power of 2, range 1..16
- LFSR_SEED, 32'hACE1ACE1, pattern word 0; must be nonzero

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle start request; ignored while busy_o=1
- base_adr_i  in  32  byte start address; bits [1:0] ignored (forced 0)
- num_words_i  in  24  number of 32-bit words to test
- busy_o  out  1  test in progress
- done_o  out  1  one-cycle pulse at completion
- bus_err_o  out  1  sticky: test aborted by err_i; cleared on next accepted start
- err_cnt_o  out  16  read mismatches; saturates at 16'hFFFF
- first_err_adr_o  out  32  byte address of first mismatch; 0 if none
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  write data
- wbm_sel_o  out  4  byte select; always 4'hF while cyc is asserted
- wbm_we_o  out  1  write enable
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_cti_o  out  3  cycle type identifier
- wbm_bte_o  out  2  burst type; always 2'b00 (linear)
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  bus error
- wbm_rty_i  in  1  retry

Behaviour:
- Reset: all outputs 0 immediately on wb_rst_n_i low, including mid-burst (cyc/stb drop asynchronously). FSM returns to IDLE and the LFSR reloads LFSR_SEED.
- FSM states: IDLE, WR_BURST, WR_GAP, RD_BURST, RD_GAP, DONE.
- IDLE:
  - start_i=1 latches base/num_words, clears err_cnt, first_err_adr and bus_err, and sets busy_o.
  - num_words=0 goes to DONE with no bus activity.
  - Otherwise goes to WR_BURST. cyc/stb assert in the cycle after start is sampled.
- Burst length: n = min(BURST_LEN, remaining words).
- Addressing: beat address increments by 4 on every accepted beat. Bursts are not alignment-restricted.
- CTI encoding: beats before the last use 3'b010; the last beat uses 3'b111; n=1 uses 3'b000.
- Beat accept: ack_i with stb_o asserted advances to the next beat, with new adr/dat/cti in the following cycle.
  - rty_i (without ack) keeps the same beat; stb stays asserted with unchanged outputs.
- Burst end and gap: after the last ack of a burst, cyc/stb deassert for exactly one cycle (WR_GAP / RD_GAP) before the next burst.
- Phase change: after the final write burst, the gap state reloads the LFSR to LFSR_SEED and the address to base, then the FSM enters RD_BURST.
- Pattern:
  - Word k holds the LFSR state after k advances, starting from LFSR_SEED.
  - next = {s[30:0],1'b0} ^ (s[31] ? 32'h00400007 : 0).
  - The LFSR advances only on an accepted beat (write or read).
- Read compare:
  - On each read ack, wbm_dat_i is compared with the LFSR value.
  - A mismatch increments err_cnt (saturating).
  - If err_cnt was 0 at that beat, first_err_adr latches the beat address.
- err_i:
  - Ends the cycle (cyc/stb low next cycle) and sets bus_err_o.
  - The FSM goes to DONE; remaining words are skipped.
  - err_i takes priority over a simultaneous ack_i, and the beat is not counted.
- DONE: pulses done_o for one cycle, clears busy_o and returns to IDLE. Result outputs hold until the next start.
- Simultaneous start_i and done: a start in the DONE cycle is ignored.
- The 24-bit remaining-word counter ensures no address wrap past base + 4*num_words.

Test Plan:
- Ideal slave (ack in the cycle after stb), base=0x100, num_words=3, BURST_LEN=8 -> expected:
  - writes to 0x100/0x104/0x108 with data ACE1ACE1, 598359C5, ...;
  - CTI 010, 010, 111;
  - reads back the same;
  - done_o pulse, err_cnt=0, bus_err=0.
- num_words=20, BURST_LEN=8 -> bursts of 8, 8, 4 in each phase, with exactly one idle cycle of cyc=0 between bursts. The last write is at base+0x4C.
- Slave corrupts the read of word 5 (base=0x1000) -> err_cnt=1, first_err_adr=0x1014. Two corruptions (words 5 and 9) -> err_cnt=2, first_err_adr still 0x1014.
- Slave asserts rty_i for 3 cycles on write beat 2 -> adr/dat/cti held stable across those cycles; final memory contents and err_cnt=0 are unchanged.
- err_i on read beat 4 -> cyc low next cycle, bus_err_o=1, done_o pulses, no further beats.
- Edge cases:
  - num_words=0 -> done_o pulses 2 cycles after start with no cyc activity.
  - Reset asserted mid write burst -> cyc/stb/busy are 0 asynchronously.
  - After reset release, a new start restarts from LFSR_SEED.
